fu_alu_pipe: RTL and testbench



---
 rtl/fu_alu_pipe.sv | 153 +++++++++++++++
 tb/tb_fu_alu_pipe.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fu_alu_pipe.sv
// Pipelined integer ALU functional unit: combinational compute into stage 0, delay stages
// behind it, per-stage valid/ready flow control with bubble collapse, flush and sticky overflow.
package types_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } aluop_t;
endpackage

module fu_alu_pipe
  import types_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2,
  parameter int TAG_W   = 5
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  aluop_t             in_aluop,
  input  logic               in_sat,
  input  logic [WIDTH-1:0]   in_port_a,
  input  logic [WIDTH-1:0]   in_port_b,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_overflow,
  output logic               out_negative,
  output logic               out_zero,
  output logic               sticky_ovf,
  input  logic               sticky_clr
);

  localparam int SHW = $clog2(WIDTH);
  localparam int PW  = WIDTH + TAG_W + 3;

  function automatic logic signed [WIDTH-1:0] sat_val(input logic sign_a);
    return sign_a ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
    return (sa != sb) && (sr != sa);
  endfunction

  logic signed [WIDTH-1:0] w_a;
  logic signed [WIDTH-1:0] w_b;
  logic signed [WIDTH-1:0] w_sum;
  logic signed [WIDTH-1:0] w_diff;
  logic        [SHW-1:0]   w_shamt;
  logic signed [WIDTH-1:0] w_res;
  logic                    w_ovf;
  logic        [PW-1:0]    w_dat;
  logic        [LATENCY-1:0] w_move;

  logic [LATENCY-1:0]         r_vld_p;
  logic [LATENCY-1:0][PW-1:0] r_dat_p;
  logic                       r_sticky;

  assign w_a     = in_port_a;
  assign w_b     = in_port_b;
  assign w_sum   = w_a + w_b;
  assign w_diff  = w_a - w_b;
  assign w_shamt = in_port_b[SHW-1:0];

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (in_aluop)
      ALU_ADD: begin
        w_ovf = add_ovf(w_a[WIDTH-1], w_b[WIDTH-1], w_sum[WIDTH-1]);
        w_res = (in_sat && w_ovf) ? sat_val(w_a[WIDTH-1]) : w_sum;
      end
      ALU_SUB: begin
        w_ovf = sub_ovf(w_a[WIDTH-1], w_b[WIDTH-1], w_diff[WIDTH-1]);
        w_res = (in_sat && w_ovf) ? sat_val(w_a[WIDTH-1]) : w_diff;
      end
      ALU_SLL:  w_res = w_a << w_shamt;
      ALU_SRL:  w_res = in_port_a >> w_shamt;
      ALU_SRA:  w_res = w_a >>> w_shamt;
      ALU_SLT:  w_res = {{(WIDTH-1){1'b0}}, (w_a < w_b)};
      ALU_SLTU: w_res = {{(WIDTH-1){1'b0}}, (in_port_a < in_port_b)};
      ALU_AND:  w_res = w_a & w_b;
      ALU_OR:   w_res = w_a | w_b;
      ALU_XOR:  w_res = w_a ^ w_b;
      default:  ;
    endcase
  end

  // Payload layout: {ovf, negative, zero, tag, result}; flags are stored so they read 0 after reset.
  assign w_dat = {w_ovf, w_res[WIDTH-1], ~|w_res, in_tag, w_res};

  // A stage may load when it is empty or everything ahead of it drains this cycle.
  always_comb begin : move_chain
    logic v_go;
    w_move = '0;
    v_go   = out_ready;
    for (int i = LATENCY - 1; i >= 0; i--) begin
      v_go      = v_go | ~r_vld_p[i];
      w_move[i] = v_go;
    end
  end

  // ---- stage 0 = registered compute, stages 1..LATENCY-1 = delay, last stage drives outputs ----
  always_ff @(posedge CLK) begin
    if (w_move[0] && in_valid) r_dat_p[0] <= w_dat;
    for (int i = 1; i < LATENCY; i++) begin
      if (w_move[i] && r_vld_p[i-1]) r_dat_p[i] <= r_dat_p[i-1];
    end

    if (RST) begin
      r_vld_p              <= '0;
      r_dat_p[LATENCY-1]   <= '0;
      r_sticky             <= 1'b0;
    end else begin
      if (flush) begin
        r_vld_p <= '0;
      end else begin
        if (w_move[0]) r_vld_p[0] <= in_valid;
        for (int i = 1; i < LATENCY; i++) begin
          if (w_move[i]) r_vld_p[i] <= r_vld_p[i-1];
        end
      end
      if (out_valid && out_ready && out_overflow) r_sticky <= 1'b1;
      else if (sticky_clr)                        r_sticky <= 1'b0;
    end
  end

  assign in_ready     = w_move[0];
  assign out_valid    = r_vld_p[LATENCY-1];
  assign out_result   = r_dat_p[LATENCY-1][WIDTH-1:0];
  assign out_tag      = r_dat_p[LATENCY-1][WIDTH+TAG_W-1:WIDTH];
  assign out_zero     = r_dat_p[LATENCY-1][PW-3];
  assign out_negative = r_dat_p[LATENCY-1][PW-2];
  assign out_overflow = r_dat_p[LATENCY-1][PW-1];
  assign sticky_ovf   = r_sticky;

endmodule

// File: tb/tb_fu_alu_pipe.sv
// Bench for fu_alu_pipe: directed corner ops plus randomized traffic against a queue-based
// model of the unit (occupancy, order, arithmetic via wide integers, sticky bit).
module tb_fu_alu_pipe;
  import types_pkg::*;

  localparam int W   = 32;
  localparam int LAT = 2;
  localparam int TW  = 5;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  aluop_t        in_aluop;
  logic          in_sat;
  logic [W-1:0]  in_port_a;
  logic [W-1:0]  in_port_b;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_result;
  logic [TW-1:0] out_tag;
  logic          out_overflow;
  logic          out_negative;
  logic          out_zero;
  logic          sticky_ovf;
  logic          sticky_clr;

  fu_alu_pipe #(.WIDTH(W), .LATENCY(LAT), .TAG_W(TW)) dut (
    .CLK(clk), .RST(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_aluop(in_aluop), .in_sat(in_sat),
    .in_port_a(in_port_a), .in_port_b(in_port_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag),
    .out_overflow(out_overflow), .out_negative(out_negative), .out_zero(out_zero),
    .sticky_ovf(sticky_ovf), .sticky_clr(sticky_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference arithmetic in 64-bit signed integers.
  function automatic void ref_alu(input aluop_t op, input logic sat, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] r, output logic ovf);
    longint sa, sb, s, mx, mn, t;
    int sh;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    mx  = (64'sd1 <<< (W - 1)) - 1;
    mn  = -mx - 1;
    sh  = int'(b % W);
    r   = '0;
    ovf = 1'b0;
    case (op)
      ALU_ADD, ALU_SUB: begin
        s   = (op == ALU_ADD) ? sa + sb : sa - sb;
        ovf = (s > mx) || (s < mn);
        if (ovf && sat) begin
          t = (s > mx) ? mx : mn;
          r = t[W-1:0];
        end else begin
          r = s[W-1:0];
        end
      end
      ALU_SLL:  r = a << sh;
      ALU_SRL:  r = a >> sh;
      ALU_SRA:  begin t = sa >>> sh; r = t[W-1:0]; end
      ALU_SLT:  r = (sa < sb) ? 1 : 0;
      ALU_SLTU: r = (a < b) ? 1 : 0;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      default:  r = '0;
    endcase
  endfunction

  typedef struct {
    logic [W-1:0]  res;
    logic [TW-1:0] tag;
    logic          ovf;
    int            pos;
  } item_t;

  item_t         mq[$];
  logic [TW-1:0] hs_tags[$];
  bit            m_sticky = 0;
  bit            mon_en = 0;
  bit            s_acc, s_hs;
  item_t         s_item;

  // Mid-cycle: compare DUT against model, capture this cycle's transfers.
  always @(negedge clk) begin
    logic [W-1:0] r;
    logic         o;
    bit           e_vld;
    if (mon_en) begin
      e_vld = (mq.size() > 0) && (mq[0].pos == LAT - 1);
      chk("in_ready", in_ready, out_ready || (mq.size() < LAT));
      chk("out_valid", out_valid, e_vld);
      chk("sticky", sticky_ovf, m_sticky);
      if (e_vld && out_valid) begin
        chk("result", out_result, mq[0].res);
        chk("tag", out_tag, mq[0].tag);
        chk("ovf", out_overflow, mq[0].ovf);
        chk("neg", out_negative, mq[0].res[W-1]);
        chk("zero", out_zero, mq[0].res == 0);
      end
    end
    s_acc = in_valid && in_ready;
    s_hs  = out_valid && out_ready;
    ref_alu(in_aluop, in_sat, in_port_a, in_port_b, r, o);
    s_item = '{res: r, tag: in_tag, ovf: o, pos: 0};
  end

  // Clock edge: advance the model.
  always @(posedge clk) begin
    int prev, np;
    if (rst) begin
      mq.delete();
      m_sticky = 0;
      mon_en   = 1;
    end else if (mon_en) begin
      if (s_hs && mq.size() > 0 && mq[0].ovf) m_sticky = 1;
      else if (sticky_clr)                    m_sticky = 0;
      if (s_hs && mq.size() > 0) begin
        hs_tags.push_back(mq[0].tag);
        void'(mq.pop_front());
      end
      prev = LAT;
      for (int k = 0; k < mq.size(); k++) begin
        np = (mq[k].pos + 1 < prev - 1) ? mq[k].pos + 1 : prev - 1;
        mq[k].pos = np;
        prev = np;
      end
      if (flush)      mq.delete();
      else if (s_acc) mq.push_back(s_item);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input aluop_t op, input logic sat, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [TW-1:0] tag, input logic fl = 1'b0);
    bit got;
    int n;
    in_valid = 1'b1; in_aluop = op; in_sat = sat;
    in_port_a = a; in_port_b = b; in_tag = tag; flush = fl;
    n = 0;
    got = 0;
    while (!got && n < 50) begin
      @(negedge clk);
      got = in_ready;
      tick();
      n++;
    end
    if (!got) chk("issue_timeout", 0, 1);
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 30) begin
      tick();
      cyc++;
    end
    if (!out_valid) chk("wait_timeout", 0, 1);
  endtask

  task automatic run_one(input string nm, input aluop_t op, input logic sat, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [TW-1:0] tag,
                         input logic [W-1:0] exp_res, input logic exp_ovf);
    int cyc;
    out_ready = 1'b1;
    issue(op, sat, a, b, tag);
    wait_valid(cyc);
    chk({nm, "_lat"}, cyc + 1, LAT);
    chk({nm, "_res"}, out_result, exp_res);
    chk({nm, "_ovf"}, out_overflow, exp_ovf);
    chk({nm, "_tag"}, out_tag, tag);
    tick();
  endtask

  task automatic clear_sticky();
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return W'($urandom_range(0, 40));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int cyc;
    int n;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_aluop = ALU_ADD; in_sat = 1'b0;
    in_port_a = '0; in_port_b = '0; in_tag = '0; out_ready = 1'b0; sticky_clr = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_result", out_result, 0);
    chk("rst_tag", out_tag, 0);
    chk("rst_flags", {out_overflow, out_negative, out_zero}, 0);
    chk("rst_sticky", sticky_ovf, 0);

    run_one("add_wrap", ALU_ADD, 1'b0, 32'h7FFF_FFFF, 32'h1, 5'd1, 32'h8000_0000, 1'b1);
    chk("add_wrap_sticky", sticky_ovf, 1);
    clear_sticky();
    chk("sticky_cleared", sticky_ovf, 0);
    run_one("add_sat", ALU_ADD, 1'b1, 32'h7FFF_FFFF, 32'h1, 5'd2, 32'h7FFF_FFFF, 1'b1);
    run_one("sub_sat", ALU_SUB, 1'b1, 32'h8000_0000, 32'h1, 5'd3, 32'h8000_0000, 1'b1);
    run_one("sub_zero", ALU_SUB, 1'b0, 32'd5, 32'd5, 5'd4, 32'h0, 1'b0);
    run_one("sra", ALU_SRA, 1'b0, 32'h8000_0000, 32'd33, 5'd5, 32'hC000_0000, 1'b0);
    run_one("sll32", ALU_SLL, 1'b1, 32'h1234_5678, 32'h20, 5'd6, 32'h1234_5678, 1'b0);
    run_one("slt", ALU_SLT, 1'b0, 32'h8000_0000, 32'h1, 5'd7, 32'h1, 1'b0);
    run_one("sltu", ALU_SLTU, 1'b0, 32'h8000_0000, 32'h1, 5'd8, 32'h0, 1'b0);
    run_one("bad_op", aluop_t'(4'd15), 1'b1, 32'h7FFF_FFFF, 32'h1, 5'd9, 32'h0, 1'b0);
    clear_sticky();

    // Back-to-back ops against a stalled consumer.
    hs_tags.delete();
    out_ready = 1'b0;
    fork
      for (int t = 0; t < 4; t++) issue(ALU_ADD, 1'b0, W'($urandom), W'($urandom), TW'(t));
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    n = 0;
    while (hs_tags.size() < 4 && n < 30) begin tick(); n++; end
    chk("bp_count", hs_tags.size(), 4);
    for (int t = 0; t < 4; t++) if (t < hs_tags.size()) chk("bp_order", hs_tags[t], t);
    clear_sticky();

    // Flush with ops in flight plus one accepted in the flush cycle.
    out_ready = 1'b1;
    hs_tags.delete();
    issue(ALU_ADD, 1'b0, 32'd1, 32'd2, 5'd10);
    issue(ALU_ADD, 1'b0, 32'd3, 32'd4, 5'd11);
    issue(ALU_XOR, 1'b0, 32'd5, 32'd6, 5'd12, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk("flush_no_valid", out_valid, 0);
      tick();
    end
    chk("flush_delivered", hs_tags.size(), 1);
    if (hs_tags.size() > 0) chk("flush_deliv_tag", hs_tags[0], 10);
    run_one("post_flush", ALU_OR, 1'b0, 32'hF0, 32'h0F, 5'd13, 32'hFF, 1'b0);

    // Reset while stalled with a valid result and sticky set.
    run_one("pre_rst", ALU_ADD, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd14, 32'hFFFF_FFFE, 1'b1);
    out_ready = 1'b0;
    issue(ALU_SUB, 1'b0, 32'd9, 32'd1, 5'd20);
    wait_valid(cyc);
    chk("stall_sticky", sticky_ovf, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_out_valid", out_valid, 0);
    chk("rst2_sticky", sticky_ovf, 0);
    chk("rst2_in_ready", in_ready, 1);
    chk("rst2_result", out_result, 0);
    chk("rst2_flags", {out_overflow, out_negative, out_zero}, 0);

    // Clear in the same cycle as an overflowed handshake: set wins.
    issue(ALU_SUB, 1'b0, 32'h8000_0000, 32'h1, 5'd21);
    wait_valid(cyc);
    sticky_clr = 1'b1;
    out_ready  = 1'b1;
    tick();
    sticky_clr = 1'b0;
    chk("set_beats_clr", sticky_ovf, 1);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 255) == 0);
      flush      = ($urandom_range(0, 63) == 0);
      sticky_clr = ($urandom_range(0, 15) == 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      in_aluop   = aluop_t'(4'($urandom_range(0, 15)));
      in_sat     = 1'($urandom_range(0, 1));
      in_port_a  = rnd_opnd();
      in_port_b  = rnd_opnd();
      in_tag     = TW'($urandom);
      tick();
    end
    rst = 1'b0; flush = 1'b0; sticky_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
